// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA field widths, delay-line bound and the packed
//                timing-group struct used by the draw-chain stages.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 11;
  localparam int RGB_W    = 12;

  // Deepest delay any balancing stage may be configured for.
  localparam int DLY_MAX  = 16;

  // Everything that travels with the raster position, excluding colour.
  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
  } vga_tim_t;

  function automatic int max_dly(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA draw-chain bundle: raster counters, sync and blanking
//                strobes and the 12-bit colour that goes with them.
//  Modports    : in  - consumer side (all fields are inputs)
//                out - producer side (all fields are outputs)
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;
  import vga_pkg::*;

  logic [HCOUNT_W-1:0] hcount;
  logic [VCOUNT_W-1:0] vcount;
  logic                hsync;
  logic                vsync;
  logic                hblnk;
  logic                vblnk;
  logic [RGB_W-1:0]    rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line
//  Description : Fixed-depth shift register with synchronous clear. Every
//                stage advances once per clock; no enable, no stall.
//  Parameters  : WIDTH - bits per stage
//                DEPTH - number of stages (0 gives a straight wire)
//  Ports       : clk  in   clock
//                rst  in   synchronous active-high clear of every stage
//                din  in   WIDTH-bit sample entering stage 0
//                dout out  WIDTH-bit sample leaving the last stage
//  Revision    : 1.0  initial release
// ============================================================================
module delay_line
  import vga_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 0 || DEPTH > DLY_MAX) begin : g_bad_depth
    $error("delay_line: DEPTH out of range 0..%0d", DLY_MAX);
  end

  if (DEPTH == 0) begin : g_pass
    // Zero depth lets a caller put its own final register after this line.
    logic w_unused_ctl;
    assign w_unused_ctl = clk ^ rst;
    assign dout         = din;
  end else begin : g_regs
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_stage[i] <= '0;
        end
      end else begin
        r_stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign dout = r_stage[DEPTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/vga_delay_align.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_align
//  Description : VGA pipeline-balancing stage. Delays the timing group by
//                TIM_DLY cycles and the colour by RGB_DLY cycles so timing
//                lines up with a colour result that arrives late. 'primed'
//                goes high once every output stage holds post-reset data.
//  Parameters  : RGB_DLY - colour delay, 1..16
//                TIM_DLY - timing-group delay, 1..16
//  Ports       : clk    in   pixel clock
//                rst    in   synchronous active-high reset
//                vii    in   incoming timing + rgb (vga_if.in)
//                vio    out  delayed timing + rgb, flop-driven (vga_if.out)
//                primed out  high once both lines have filled since reset
//  Options     : VGA_DELAY_ALIGN_BLANK_MASK_EN - when defined, vio.rgb is
//                forced to 0 on every cycle where vio.hblnk | vio.vblnk.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_delay_align
  import vga_pkg::*;
#(
  parameter int RGB_DLY = 3,
  parameter int TIM_DLY = 1
) (
  input  logic      clk,
  input  logic      rst,
  vga_if.in         vii,
  vga_if.out        vio,
  output logic      primed
);

  localparam int c_MAX_DLY = max_dly(RGB_DLY, TIM_DLY);
  localparam int c_CNT_W   = $clog2(c_MAX_DLY + 1);
  localparam logic [c_CNT_W-1:0] c_FILL_FULL = c_CNT_W'(c_MAX_DLY);

  if (RGB_DLY < 1 || RGB_DLY > DLY_MAX) begin : g_bad_rgb_dly
    $error("vga_delay_align: RGB_DLY must be in 1..%0d", DLY_MAX);
  end
  if (TIM_DLY < 1 || TIM_DLY > DLY_MAX) begin : g_bad_tim_dly
    $error("vga_delay_align: TIM_DLY must be in 1..%0d", DLY_MAX);
  end

  // --------------------------------------------------------------------------
  // Timing group
  // --------------------------------------------------------------------------
  vga_tim_t w_tim_in;
  vga_tim_t w_tim_out;

  assign w_tim_in = '{hcount: vii.hcount, vcount: vii.vcount,
                      hsync:  vii.hsync,  vsync:  vii.vsync,
                      hblnk:  vii.hblnk,  vblnk:  vii.vblnk};

  delay_line #(
    .WIDTH ($bits(vga_tim_t)),
    .DEPTH (TIM_DLY)
  ) u_tim_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (w_tim_in),
    .dout (w_tim_out)
  );

  assign vio.hcount = w_tim_out.hcount;
  assign vio.vcount = w_tim_out.vcount;
  assign vio.hsync  = w_tim_out.hsync;
  assign vio.vsync  = w_tim_out.vsync;
  assign vio.hblnk  = w_tim_out.hblnk;
  assign vio.vblnk  = w_tim_out.vblnk;

  // --------------------------------------------------------------------------
  // Colour
  // --------------------------------------------------------------------------
  logic [RGB_W-1:0] w_rgb_out;

`ifdef VGA_DELAY_ALIGN_BLANK_MASK_EN
  // The last colour stage lives here so it can be cleared on the same edge
  // that loads a blanking sample into the last timing stage. The blank bit
  // is carried TIM_DLY-1 stages so it is exactly what that stage is loading.
  logic [RGB_W-1:0] w_rgb_pre;
  logic [RGB_W-1:0] r_rgb_last;
  logic             w_blank_in;
  logic             w_blank_next;

  assign w_blank_in = vii.hblnk | vii.vblnk;

  delay_line #(
    .WIDTH (RGB_W),
    .DEPTH (RGB_DLY - 1)
  ) u_rgb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (vii.rgb),
    .dout (w_rgb_pre)
  );

  delay_line #(
    .WIDTH (1),
    .DEPTH (TIM_DLY - 1)
  ) u_blank_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (w_blank_in),
    .dout (w_blank_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_last <= '0;
    end else if (w_blank_next) begin
      r_rgb_last <= '0;
    end else begin
      r_rgb_last <= w_rgb_pre;
    end
  end

  assign w_rgb_out = r_rgb_last;
`else
  delay_line #(
    .WIDTH (RGB_W),
    .DEPTH (RGB_DLY)
  ) u_rgb_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (vii.rgb),
    .dout (w_rgb_out)
  );
`endif

  assign vio.rgb = w_rgb_out;

  // --------------------------------------------------------------------------
  // Fill tracking: counts non-reset cycles up to the deeper line's depth.
  // 'primed' is registered from the next count so it rises on the same edge
  // that loads the first valid sample into the deeper line's last stage.
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] r_fill_cnt;
  logic [c_CNT_W-1:0] w_fill_next;
  logic               r_primed;

  always_comb begin
    w_fill_next = r_fill_cnt;
    if (r_fill_cnt != c_FILL_FULL) begin
      w_fill_next = r_fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_cnt <= '0;
      r_primed   <= 1'b0;
    end else begin
      r_fill_cnt <= w_fill_next;
      r_primed   <= (w_fill_next == c_FILL_FULL);
    end
  end

  assign primed = r_primed;

endmodule
`default_nettype wire

// File: tb/tb_vga_delay_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_delay_align
//  Description : Directed self-checking bench. Three instances cover the
//                default 3/1 delays, a 5/2 ramp and equal 4/4 delays.
//                Expected colour during blanking follows
//                VGA_DELAY_ALIGN_BLANK_MASK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_delay_align;
  import vga_pkg::*;

`ifdef VGA_DELAY_ALIGN_BLANK_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic primed0, primed1, primed2;

  vga_if vi0 ();
  vga_if vo0 ();
  vga_if vi1 ();
  vga_if vo1 ();
  vga_if vi2 ();
  vga_if vo2 ();

  vga_delay_align #(.RGB_DLY(3), .TIM_DLY(1)) u_dut0 (
    .clk(clk), .rst(rst0), .vii(vi0), .vio(vo0), .primed(primed0));
  vga_delay_align #(.RGB_DLY(5), .TIM_DLY(2)) u_dut1 (
    .clk(clk), .rst(rst1), .vii(vi1), .vio(vo1), .primed(primed1));
  vga_delay_align #(.RGB_DLY(4), .TIM_DLY(4)) u_dut2 (
    .clk(clk), .rst(rst2), .vii(vi2), .vio(vo2), .primed(primed2));

  int n_asserts = 0;
  int n_fails   = 0;

  // Defaults 3/1: outputs clear while held in reset, then hcount after 1,
  // rgb after 3 and primed on the 3rd edge.
  task automatic test_reset();
    logic [49:0] got;
    vi0.hcount = 11'd100; vi0.vcount = 11'd7;
    vi0.hsync = 1'b1; vi0.vsync = 1'b1; vi0.hblnk = 1'b0; vi0.vblnk = 1'b0;
    vi0.rgb = 12'hFFF;
    rst0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = {vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync,
             vo0.hblnk, vo0.vblnk, vo0.rgb, primed0};
      n_asserts++;
      if (got !== '0) begin
        n_fails++;
        $display("FAIL reset_clear cyc=%0d: got %h expected 0", i, got);
      end
    end
    rst0 = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      n_asserts++;
      if (vo0.hcount !== 11'd100) begin
        n_fails++;
        $display("FAIL reset_hcount n=%0d: got %0d expected 100", n, vo0.hcount);
      end
      n_asserts++;
      if (vo0.rgb !== ((n >= 3) ? 12'hFFF : 12'h000)) begin
        n_fails++;
        $display("FAIL reset_rgb n=%0d: got %h", n, vo0.rgb);
      end
      n_asserts++;
      if (primed0 !== (n >= 3)) begin
        n_fails++;
        $display("FAIL reset_primed n=%0d: got %b expected %b", n, primed0, n >= 3);
      end
    end
  endtask

  // 5/2 ramp: rgb mirrors hcount, so once primed rgb trails hcount by 3.
  task automatic test_ramp_alignment();
    vi1.hcount = '0; vi1.vcount = '0; vi1.hsync = 1'b0; vi1.vsync = 1'b0;
    vi1.hblnk = 1'b0; vi1.vblnk = 1'b0; vi1.rgb = '0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int n = 1; n <= 800; n++) begin
      vi1.hcount = 11'(n - 1);
      vi1.rgb    = 12'(n - 1);
      @(posedge clk); #1;
      n_asserts++;
      if (primed1 !== (n >= 5)) begin
        n_fails++;
        $display("FAIL ramp_primed n=%0d: got %b expected %b", n, primed1, n >= 5);
      end
      if (n >= 2) begin
        n_asserts++;
        if (vo1.hcount !== 11'(n - 2)) begin
          n_fails++;
          $display("FAIL ramp_hcount n=%0d: got %0d expected %0d", n, vo1.hcount, n - 2);
        end
      end
      if (n >= 5) begin
        n_asserts++;
        if (vo1.rgb !== 12'(n - 5)) begin
          n_fails++;
          $display("FAIL ramp_rgb n=%0d: got %0d expected %0d", n, vo1.rgb, n - 5);
        end
      end
    end
  endtask

  // 4/4 with random fields: every output is the input from 4 edges earlier.
  task automatic test_equal_delays();
    logic [37:0] hist [1:40];
    logic [37:0] exp_v;
    logic [37:0] got;
    logic [63:0] rnd;
    {vi2.hcount, vi2.vcount, vi2.hsync, vi2.vsync,
     vi2.hblnk, vi2.vblnk, vi2.rgb} = '0;
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    n_asserts++;
    if (primed2 !== 1'b0) begin
      n_fails++;
      $display("FAIL equal_reset_primed: got %b expected 0", primed2);
    end
    for (int n = 1; n <= 40; n++) begin
      rnd = {$urandom(), $urandom()};
      hist[n] = rnd[37:0];
      {vi2.hcount, vi2.vcount, vi2.hsync, vi2.vsync,
       vi2.hblnk, vi2.vblnk, vi2.rgb} = hist[n];
      @(posedge clk); #1;
      exp_v = '0;
      if (n >= 4) exp_v = hist[n - 3];
      if (MASK_ON && (exp_v[13] | exp_v[12])) exp_v[11:0] = '0;
      got = {vo2.hcount, vo2.vcount, vo2.hsync, vo2.vsync,
             vo2.hblnk, vo2.vblnk, vo2.rgb};
      n_asserts++;
      if (got !== exp_v) begin
        n_fails++;
        $display("FAIL equal_fields n=%0d: got %h expected %h", n, got, exp_v);
      end
      n_asserts++;
      if (primed2 !== (n >= 4)) begin
        n_fails++;
        $display("FAIL equal_primed n=%0d: got %b expected %b", n, primed2, n >= 4);
      end
    end
  endtask

  // 3/1 single-cycle reset at hcount=400 while primed, then refill.
  task automatic test_mid_frame_reset();
    logic [49:0] got;
    vi0.vcount = 11'd20; vi0.hsync = 1'b0; vi0.vsync = 1'b0;
    vi0.hblnk = 1'b0; vi0.vblnk = 1'b0;
    for (int h = 390; h < 400; h++) begin
      vi0.hcount = 11'(h);
      vi0.rgb    = 12'(h);
      @(posedge clk); #1;
    end
    n_asserts++;
    if (primed0 !== 1'b1 || vo0.rgb !== 12'd397) begin
      n_fails++;
      $display("FAIL mid_pre: got primed=%b rgb=%0d expected 1/397", primed0, vo0.rgb);
    end
    vi0.hcount = 11'd400; vi0.rgb = 12'd400;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    got = {vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync,
           vo0.hblnk, vo0.vblnk, vo0.rgb, primed0};
    n_asserts++;
    if (got !== '0) begin
      n_fails++;
      $display("FAIL mid_clear: got %h expected 0", got);
    end
    for (int n = 1; n <= 8; n++) begin
      vi0.hcount = 11'(400 + n);
      vi0.rgb    = 12'(400 + n);
      @(posedge clk); #1;
      n_asserts++;
      if (vo0.hcount !== 11'(400 + n)) begin
        n_fails++;
        $display("FAIL mid_hcount n=%0d: got %0d expected %0d", n, vo0.hcount, 400 + n);
      end
      n_asserts++;
      if (vo0.rgb !== ((n >= 3) ? 12'(398 + n) : 12'd0)) begin
        n_fails++;
        $display("FAIL mid_rgb n=%0d: got %0d", n, vo0.rgb);
      end
      n_asserts++;
      if (primed0 !== (n >= 3)) begin
        n_fails++;
        $display("FAIL mid_primed n=%0d: got %b expected %b", n, primed0, n >= 3);
      end
    end
  endtask

  // 3/1 constant colour across a horizontal blanking interval.
  task automatic test_blank_mask();
    int h;
    logic exp_hb;
    logic [11:0] exp_rgb;
    vi0.hcount = '0; vi0.vcount = 11'd5; vi0.hsync = 1'b0; vi0.vsync = 1'b0;
    vi0.hblnk = 1'b0; vi0.vblnk = 1'b0; vi0.rgb = 12'hABC;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    for (int n = 1; n <= 296; n++) begin
      h = (n <= 276) ? (779 + n) : (n - 277);
      vi0.hcount = 11'(h);
      vi0.hblnk  = (h >= 800);
      @(posedge clk); #1;
      exp_hb  = (h >= 800);
      exp_rgb = (n < 3) ? 12'h000 : ((MASK_ON && exp_hb) ? 12'h000 : 12'hABC);
      n_asserts++;
      if (vo0.hcount !== 11'(h) || vo0.hblnk !== exp_hb) begin
        n_fails++;
        $display("FAIL mask_timing n=%0d: got h=%0d hb=%b expected h=%0d hb=%b",
                 n, vo0.hcount, vo0.hblnk, h, exp_hb);
      end
      n_asserts++;
      if (vo0.rgb !== exp_rgb) begin
        n_fails++;
        $display("FAIL mask_rgb n=%0d h=%0d: got %h expected %h", n, h, vo0.rgb, exp_rgb);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    {vi0.hcount, vi0.vcount, vi0.hsync, vi0.vsync, vi0.hblnk, vi0.vblnk, vi0.rgb} = '0;
    {vi1.hcount, vi1.vcount, vi1.hsync, vi1.vsync, vi1.hblnk, vi1.vblnk, vi1.rgb} = '0;
    {vi2.hcount, vi2.vcount, vi2.hsync, vi2.vsync, vi2.hblnk, vi2.vblnk, vi2.rgb} = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ramp_alignment();
    test_equal_delays();
    test_mid_frame_reset();
    test_blank_mask();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_delay_align.md
# vga_delay_align

- Parametrised VGA pipeline-balancing stage.
- Delays the colour bus and the timing group by independently chosen cycle counts, so downstream timing lines up with a colour result that arrives several cycles late (e.g. from ROM/char lookups).
- Asserts a `primed` flag once every output stage holds post-reset data.
- Sits between any colour-producing stage and the next `vga_if` consumer in the draw chain.

## Interface
Parameters:
- `RGB_DLY`, 3: cycles from `vii.rgb` to `vio.rgb`; legal range 1..16.
- `TIM_DLY`, 1: cycles from `vii` timing fields (hcount, vcount, hsync, vsync, hblnk, vblnk) to `vio`; legal range 1..16.

Ports:
- `clk`  in  1  pixel clock. One clock domain.
- `rst`  in  1  reset: synchronous, active-high.
- `vii`  vga_if.in  —  incoming timing and rgb (hcount/vcount 11 b, rgb 12 b).
- `vio`  vga_if.out  —  delayed timing and rgb, all fields driven from flops.
- `primed`  out  1  high once both delay lines are fully filled since the last reset.

## Operation
- Timing group: a shift register of depth `TIM_DLY`; each field moves one stage per clock, with no gating.
- Colour: a separate shift register of depth `RGB_DLY`.
- Each output is the last stage of its line.
- Fill counter `fill_cnt`:
  - Width `$clog2(MAX_DLY+1)`, where `MAX_DLY = max(RGB_DLY, TIM_DLY)`.
  - Increments every non-reset cycle and saturates at `MAX_DLY`.
  - `primed = (fill_cnt == MAX_DLY)`, registered.
- Reset (any cycle, including mid-frame):
  - Every stage of both lines clears to 0, so all `vio` fields become 0.
  - `fill_cnt` clears to 0 and `primed` to 0.
  - Refill restarts from the first non-reset cycle.
- No flow control: the block never stalls and never drops a sample.
- Out-of-range parameters raise an elaboration-time `$error`.

## Timing
- Reset values: `vio.hcount=0`, `vio.vcount=0`, `vio.hsync=0`, `vio.vsync=0`, `vio.hblnk=0`, `vio.vblnk=0`, `vio.rgb=0`, `primed=0`.
- `vio.<timing>(t) = vii.<timing>(t - TIM_DLY)`.
- `vio.rgb(t) = vii.rgb(t - RGB_DLY)`, subject to masking (see Configuration).
- Relative skew: colour lags timing by `RGB_DLY - TIM_DLY` cycles, which may be negative.
- `rst` deasserted on edge k: `primed` rises on edge `k + MAX_DLY` and stays high until the next reset.
- Equal delays: the two lines behave identically cycle for cycle; no special case is needed.
- A reset pulse of one cycle is sufficient.

## Configuration
Macro `VGA_DELAY_ALIGN_BLANK_MASK_EN`:
- Defined:
  - The final rgb stage loads 0 whenever the value loading into the final timing stage on the same edge has `hblnk | vblnk = 1`.
  - Result: `vio.rgb` is 0 on every cycle where `vio.hblnk | vio.vblnk`.
  - Latency is unchanged and outputs remain flop-driven.
- Undefined: rgb passes through unmasked, and any colour present during blanking appears on `vio.rgb`.

## Structure
Shared package `vga_pkg`:
- `HCOUNT_W = 11`, `VCOUNT_W = 11`, `RGB_W = 12`.
- `DLY_MAX = 16`.
- Packed struct `vga_tim_t` holding {hcount, vcount, hsync, vsync, hblnk, vblnk}.

Sub-module `delay_line`:
- Parameters `WIDTH`, `DEPTH`.
- Ports `clk`, `rst`, `din`, `dout`.
- Behaviour: synchronous clear to 0.
- Instantiated twice: `WIDTH = $bits(vga_tim_t)` for timing, `WIDTH = RGB_W` for colour.

Top level holds: the two `delay_line` instances, the fill counter, and the optional mask.

## Test plan
- Reset, defaults (3/1): hold `rst` 2 cycles with `vii.rgb=12'hFFF`, `vii.hcount=100` -> all `vio` fields 0 and `primed=0` during reset. After release, `vio.hcount=100` 1 cycle later, `vio.rgb=12'hFFF` 3 cycles later, `primed=1` on the 3rd edge.
- Ramp alignment (`RGB_DLY=5`, `TIM_DLY=2`): drive `vii.rgb = hcount[11:0]` with `hcount` incrementing 0..799 -> `vio.rgb == vio.hcount - 3` on every cycle after `primed`.
- Equal delays (4/4): random stimulus -> `vio` equals the 4-cycle-delayed `vii` on all fields, and `primed` rises exactly 4 edges after reset.
- Mid-frame reset: assert `rst` for 1 cycle at `hcount=400` -> next-cycle outputs are all 0 and `primed=0`; refill completes after `MAX_DLY` cycles and alignment resumes.
- Mask enabled (`VGA_DELAY_ALIGN_BLANK_MASK_EN`, 3/1): drive `vii.rgb=12'hABC` continuously with `hblnk` high for hcount 800..1055 -> `vio.rgb=0` on exactly the cycles where `vio.hblnk=1`, and `12'hABC` elsewhere.
- Mask disabled, same stimulus -> `vio.rgb=12'hABC` on every primed cycle, including during blanking.
